nrdiv_r2: RTL and testbench

//  Sequential signed non-restoring radix-2 divider. It is the inverse companion of the

---
 rtl/nrdiv_r2.sv | 131 +++++++++++++
 tb/tb_nrdiv_r2.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/nrdiv_r2.sv
// nrdiv_r2: sequential signed non-restoring radix-2 divider.
// Operands arrive one per cycle on inbus: the dividend first, then the divisor.
// Results leave one per cycle on outbus: the remainder first, then the quotient.
// The core iterates on operand magnitudes. Signs are applied once, in FIX, and
// the division truncates toward zero.
module nrdiv_r2 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [WIDTH-1:0] inbus,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] outbus
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD_DVS,
      ITER,
      FIX,
      OUT_R,
      OUT_Q
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] dvd;
   logic [WIDTH:0]   a;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] m;
   logic [WIDTH-1:0] quo;
   logic             sd;
   logic             sv;
   logic [CW-1:0]    cnt;

   logic [WIDTH:0]   a_shift;
   logic [WIDTH:0]   a_next;
   logic [WIDTH-1:0] a_fix;
   logic [WIDTH-1:0] rem_fix;
   logic [WIDTH-1:0] quo_fix;
   logic [WIDTH-1:0] dvd_mag;
   logic [WIDTH-1:0] dvs_mag;

   // Combinational datapath: one non-restoring step, the final restore, sign fix-up
   // and the operand magnitudes (the magnitude of the most negative value wraps to
   // the 2^(W-1) pattern, which is its correct unsigned magnitude)
   always_comb begin
      a_shift = {a[WIDTH-1:0], q[WIDTH-1]};
      a_next  = a[WIDTH] ? (a_shift + {1'b0, m}) : (a_shift - {1'b0, m});
      a_fix   = a[WIDTH] ? (a[WIDTH-1:0] + m) : a[WIDTH-1:0];
      rem_fix = sd ? (~a_fix + 1'b1) : a_fix;
      quo_fix = sv ? (~q + 1'b1) : q;
      dvd_mag = dvd[WIDTH-1] ? (~dvd + 1'b1) : dvd;
      dvs_mag = inbus[WIDTH-1] ? (~inbus + 1'b1) : inbus;
   end

   // Control FSM with registered result outputs; reset aborts any operation in progress
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         dvd         <= '0;
         a           <= '0;
         q           <= '0;
         m           <= '0;
         quo         <= '0;
         sd          <= 1'b0;
         sv          <= 1'b0;
         cnt         <= '0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         outbus      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (enable) begin
                  dvd   <= inbus;
                  state <= LOAD_DVS;
               end
            end
            LOAD_DVS: begin
               if (inbus == '0) begin
                  done        <= 1'b1;
                  div_by_zero <= 1'b1;
                  outbus      <= dvd;
                  quo         <= '1;
                  state       <= OUT_R;
               end else begin
                  sd    <= dvd[WIDTH-1];
                  sv    <= dvd[WIDTH-1] ^ inbus[WIDTH-1];
                  q     <= dvd_mag;
                  m     <= dvs_mag;
                  a     <= '0;
                  cnt   <= '0;
                  state <= ITER;
               end
            end
            ITER: begin
               a   <= a_next;
               q   <= {q[WIDTH-2:0], ~a_next[WIDTH]};
               cnt <= cnt + CW'(1);
               if (cnt == CW'(WIDTH - 1)) begin
                  state <= FIX;
               end
            end
            FIX: begin
               done   <= 1'b1;
               outbus <= rem_fix;
               quo    <= quo_fix;
               state  <= OUT_R;
            end
            OUT_R: begin
               outbus <= quo;
               state  <= OUT_Q;
            end
            OUT_Q: begin
               done        <= 1'b0;
               div_by_zero <= 1'b0;
               outbus      <= '0;
               state       <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nrdiv_r2.sv
// tb_nrdiv_r2: directed and swept checks of the signed non-restoring divider.
// Each cycle of an operation is compared as the packed word {done, div_by_zero, outbus}.
module tb_nrdiv_r2;

   logic       clk;
   logic       rst;
   logic       enable;
   logic [7:0] inbus;
   logic       done;
   logic       div_by_zero;
   logic [7:0] outbus;

   int checks;
   int failures;

   nrdiv_r2 #(.WIDTH(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .inbus       (inbus),
      .done        (done),
      .div_by_zero (div_by_zero),
      .outbus      (outbus)
   );

   // Free-running 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compares one observed value against its expected value and records the result
   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Returns {remainder, quotient} for truncating signed division, computed with native int arithmetic
   function automatic logic [15:0] refDiv(input logic [7:0] x, input logic [7:0] y);
      int xi;
      int yi;
      int qi;
      int ri;
      xi = int'($signed(x));
      yi = int'($signed(y));
      if (yi == 0) begin
         return {x, 8'hFF};
      end
      qi = xi / yi;
      ri = xi % yi;
      return {ri[7:0], qi[7:0]};
   endfunction

   // Runs one division, starting at a negedge with the DUT in IDLE (or in OUT_Q when b2b is set).
   // Every cycle from the start to OUT_Q is compared. When hold is set, enable stays high throughout.
   task automatic applyStimulus(input string tag, input logic [7:0] dvd, input logic [7:0] dvs,
                                input logic [7:0] expRem, input logic [7:0] expQuo,
                                input logic expDbz, input bit hold, input bit b2b);
      int latR;
      int latQ;
      logic [15:0] expWord;
      latR = expDbz ? 2 : 11;
      latQ = latR + 1;
      enable = 1'b1;
      inbus  = dvd;
      if (b2b) begin
         @(posedge clk);
         @(negedge clk);
         checkOutput({tag, "_gap"}, {6'd0, done, div_by_zero, outbus}, 16'h0000);
      end
      @(posedge clk);
      @(negedge clk);
      inbus  = dvs;
      enable = hold;
      checkOutput({tag, "_c1"}, {6'd0, done, div_by_zero, outbus}, 16'h0000);
      for (int k = 2; k <= latQ; k++) begin
         @(posedge clk);
         @(negedge clk);
         inbus = 8'h55;
         if (k == latR)
            expWord = {6'd0, 1'b1, expDbz, expRem};
         else if (k == latQ)
            expWord = {6'd0, 1'b1, expDbz, expQuo};
         else
            expWord = 16'h0000;
         checkOutput($sformatf("%s_c%0d", tag, k), {6'd0, done, div_by_zero, outbus}, expWord);
      end
      if (!hold) begin
         @(posedge clk);
         @(negedge clk);
         checkOutput({tag, "_idle"}, {6'd0, done, div_by_zero, outbus}, 16'h0000);
      end
   endtask

   // Stimulus sequence: reset, directed vectors, reset abort, back-to-back ops, operand sweep
   initial begin
      logic [7:0]  sDvd;
      logic [7:0]  sDvs;
      logic [15:0] sRef;
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      enable   = 1'b1;
      inbus    = 8'h64;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset", {6'd0, done, div_by_zero, outbus}, 16'h0000);
      rst    = 1'b0;
      enable = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkOutput("post_reset_idle", {6'd0, done, div_by_zero, outbus}, 16'h0000);

      applyStimulus("p100_7",    8'h64, 8'h07, 8'h02, 8'h0E, 1'b0, 1'b0, 1'b0);
      applyStimulus("m100_7",    8'h9C, 8'h07, 8'hFE, 8'hF2, 1'b0, 1'b0, 1'b0);
      applyStimulus("p100_m7",   8'h64, 8'hF9, 8'h02, 8'hF2, 1'b0, 1'b0, 1'b0);
      applyStimulus("m100_m7",   8'h9C, 8'hF9, 8'hFE, 8'h0E, 1'b0, 1'b0, 1'b0);
      applyStimulus("p5_0",      8'h05, 8'h00, 8'h05, 8'hFF, 1'b1, 1'b0, 1'b0);
      applyStimulus("m128_0",    8'h80, 8'h00, 8'h80, 8'hFF, 1'b1, 1'b0, 1'b0);
      applyStimulus("m128_m1",   8'h80, 8'hFF, 8'h00, 8'h80, 1'b0, 1'b0, 1'b0);
      applyStimulus("m128_p1",   8'h80, 8'h01, 8'h00, 8'h80, 1'b0, 1'b0, 1'b0);
      applyStimulus("p7_m128",   8'h07, 8'h80, 8'h07, 8'h00, 1'b0, 1'b0, 1'b0);
      applyStimulus("m128_m128", 8'h80, 8'h80, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0);
      applyStimulus("p0_5",      8'h00, 8'h05, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      applyStimulus("p127_1",    8'h7F, 8'h01, 8'h00, 8'h7F, 1'b0, 1'b0, 1'b0);

      // Abort 100/7 with a reset pulse during ITER
      enable = 1'b1;
      inbus  = 8'h64;
      @(posedge clk);
      @(negedge clk);
      enable = 1'b0;
      inbus  = 8'h07;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checkOutput("rst_abort", {6'd0, done, div_by_zero, outbus}, 16'h0000);
      for (int k = 0; k < 14; k++) begin
         @(posedge clk);
         @(negedge clk);
         checkOutput($sformatf("rst_quiet_%0d", k), {6'd0, done, div_by_zero, outbus}, 16'h0000);
      end
      applyStimulus("p50_6", 8'h32, 8'h06, 8'h02, 8'h08, 1'b0, 1'b0, 1'b0);

      // Back-to-back with enable held high through the first operation
      applyStimulus("p27_4", 8'h1B, 8'h04, 8'h03, 8'h06, 1'b0, 1'b1, 1'b0);
      applyStimulus("m27_4", 8'hE5, 8'h04, 8'hFD, 8'hFA, 1'b0, 1'b0, 1'b1);

      // Swept operands against the native truncating-division reference
      for (int i = 0; i < 40; i++) begin
         sDvd = 8'($urandom_range(0, 255));
         sDvs = 8'($urandom_range(0, 255));
         if (i % 5 == 0) sDvs = 8'h00;
         if (i % 7 == 0) sDvd = 8'h80;
         if (i % 11 == 3) sDvs = 8'h80;
         if (i % 13 == 4) sDvs = 8'hFF;
         sRef = refDiv(sDvd, sDvs);
         applyStimulus($sformatf("sweep%0d_%h_%h", i, sDvd, sDvs), sDvd, sDvs,
                       sRef[15:8], sRef[7:0], (sDvs == 8'h00), 1'b0, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
